// File: rtl/menu_pkg.sv
// ============================================================================
// Module  : menu_pkg
// Brief   : Shared types and default timing constants for the parameter menu.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package menu_pkg;

  typedef enum logic [1:0] {
    BROWSE = 2'd0,
    EDIT   = 2'd1,
    COMMIT = 2'd2
  } menu_state_t;

  typedef enum logic [1:0] {
    BTN_UP   = 2'd0,
    BTN_DOWN = 2'd1,
    BTN_NEXT = 2'd2,
    BTN_SET  = 2'd3
  } btn_idx_t;

  localparam int c_num_btns          = 4;
  localparam int c_hold_cycles_def   = 32_500_000;  // 0.5 s at 65 MHz
  localparam int c_repeat_cycles_def = 6_500_000;   // 0.1 s at 65 MHz

endpackage

`default_nettype wire

// File: rtl/button_repeater.sv
// ============================================================================
// Module  : button_repeater
// Brief   : Level button to one-cycle event on release, with optional
//           hold-to-auto-repeat; held reports the registered level.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module button_repeater #(
  parameter int HOLD_CYCLES   = 32_500_000,
  parameter int REPEAT_CYCLES = 6_500_000,
  parameter bit REPEAT_EN     = 1'b1
) (
  input  logic clk_65mhz,
  input  logic rst,
  input  logic btn,
  output logic event_pulse,
  output logic held
);

  localparam int c_hold_w = $clog2(HOLD_CYCLES + 1);
  localparam int c_rep_w  = $clog2(REPEAT_CYCLES + 1);
  localparam logic [c_hold_w-1:0] c_hold_max  = c_hold_w'(HOLD_CYCLES);
  localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(HOLD_CYCLES - 1);
  localparam logic [c_rep_w-1:0]  c_rep_last  = c_rep_w'(REPEAT_CYCLES - 1);

  logic                r_prev;
  logic                r_event;
  logic [c_hold_w-1:0] r_hold_cnt;
  logic [c_rep_w-1:0]  r_rep_cnt;
  logic                w_long;
  logic                w_hold_hit;
  logic                w_rep_hit;
  logic                w_release;
  logic                w_evt;

  // Once the hold threshold is reached the press has been consumed by the
  // repeat stream, so its release must stay silent.
  always_comb begin
    w_long     = (r_hold_cnt == c_hold_max);
    w_hold_hit = btn && (r_hold_cnt == c_hold_last);
    w_rep_hit  = btn && w_long && (r_rep_cnt == c_rep_last);
    w_release  = !btn && r_prev;
    if (REPEAT_EN) begin
      w_evt = w_hold_hit || w_rep_hit || (w_release && !w_long);
    end else begin
      w_evt = w_release;
    end
  end

  always_ff @(posedge clk_65mhz) begin
    if (rst) begin
      r_prev     <= 1'b0;
      r_event    <= 1'b0;
      r_hold_cnt <= '0;
      r_rep_cnt  <= '0;
    end else begin
      r_prev  <= btn;
      r_event <= w_evt;
      if (!btn) begin
        r_hold_cnt <= '0;
      end else if (!w_long) begin
        r_hold_cnt <= r_hold_cnt + 1'b1;
      end
      if (!btn || !w_long || w_rep_hit) begin
        r_rep_cnt <= '0;
      end else begin
        r_rep_cnt <= r_rep_cnt + 1'b1;
      end
    end
  end

  assign event_pulse = r_event;
  assign held        = r_prev;

endmodule

`default_nettype wire

// File: rtl/param_menu.sv
// ============================================================================
// Module  : param_menu
// Brief   : N-entry parameter menu with staged edits, commit/cancel and
//           hold-to-repeat, driven by four debounced buttons.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module param_menu
  import menu_pkg::*;
#(
  parameter int NUM_PARAMS    = 5,
  parameter int VAL_W         = 3,
  parameter logic [NUM_PARAMS*VAL_W-1:0] PARAM_MAX = {3'd2, 3'd4, 3'd1, 3'd1, 3'd3},
  parameter logic [NUM_PARAMS*VAL_W-1:0] PARAM_RST = '0,
  parameter int HOLD_CYCLES   = c_hold_cycles_def,
  parameter int REPEAT_CYCLES = c_repeat_cycles_def,
  localparam int SEL_W        = $clog2(NUM_PARAMS)
) (
  input  logic                        clk_65mhz,
  input  logic                        rst,
  input  logic                        up,
  input  logic                        down,
  input  logic                        next,
  input  logic                        set,
  output logic [NUM_PARAMS*VAL_W-1:0] values,
  output logic [VAL_W-1:0]            staged_val,
  output logic [SEL_W-1:0]            selector_val,
  output logic                        editing,
  output logic                        commit_pulse,
  output logic [1:0]                  menu_state
);

  localparam logic [SEL_W-1:0] c_sel_last = SEL_W'(NUM_PARAMS - 1);

  menu_state_t                 r_state, w_state_next;
  logic [SEL_W-1:0]            r_sel, w_sel_next;
  logic [VAL_W-1:0]            r_staged, w_staged_next;
  logic [NUM_PARAMS*VAL_W-1:0] r_values, w_values_next;
  logic                        r_locked, r_both, r_suppress;
  btn_idx_t                    r_owner, w_winner;
  logic [c_num_btns-1:0]       w_raw, w_gated, w_evt, w_held, w_ev;
  logic                        w_unlock, w_cancel;
  logic [VAL_W-1:0]            w_cur, w_max;

  assign w_raw = {set, next, down, up};

  // Lockout: the first-pressed button owns the repeaters until everything,
  // including the owner's registered level, has gone quiet.
  always_comb begin
    w_gated = '0;
    if (up)        w_winner = BTN_UP;
    else if (down) w_winner = BTN_DOWN;
    else if (next) w_winner = BTN_NEXT;
    else           w_winner = BTN_SET;
    if (!r_locked) begin
      if (|w_raw) w_gated[w_winner] = 1'b1;
    end else begin
      w_gated[r_owner] = w_raw[r_owner];
    end
  end

  for (genvar gi = 0; gi < c_num_btns; gi++) begin : g_btn
    button_repeater #(
      .HOLD_CYCLES  (HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES),
      .REPEAT_EN    (gi == int'(BTN_UP) || gi == int'(BTN_DOWN))
    ) u_rep (
      .clk_65mhz  (clk_65mhz),
      .rst        (rst),
      .btn        (w_gated[gi]),
      .event_pulse(w_evt[gi]),
      .held       (w_held[gi])
    );
  end

  assign w_unlock = r_locked && (w_raw == '0) && (w_held == '0);
  assign w_cancel = (r_state == EDIT) && up && down && r_both;
  // A cancel chord must not leak the owner's release event into BROWSE.
  assign w_ev     = w_evt & {c_num_btns{~r_suppress}};
  assign w_cur    = r_values[r_sel*VAL_W +: VAL_W];
  assign w_max    = PARAM_MAX[r_sel*VAL_W +: VAL_W];

  always_comb begin
    w_state_next  = r_state;
    w_sel_next    = r_sel;
    w_staged_next = r_staged;
    w_values_next = r_values;
    case (r_state)
      BROWSE: begin
        if (w_ev[BTN_UP]) begin
          w_sel_next = (r_sel == c_sel_last) ? '0 : r_sel + 1'b1;
        end else if (w_ev[BTN_DOWN]) begin
          w_sel_next = (r_sel == '0) ? c_sel_last : r_sel - 1'b1;
        end else if (w_ev[BTN_NEXT]) begin
          w_state_next  = EDIT;
          w_staged_next = (w_cur > w_max) ? w_max : w_cur;
        end
      end
      EDIT: begin
        if (w_cancel) begin
          w_state_next = BROWSE;
        end else if (w_ev[BTN_UP] || w_ev[BTN_NEXT]) begin
          w_staged_next = (r_staged >= w_max) ? '0 : r_staged + 1'b1;
        end else if (w_ev[BTN_DOWN]) begin
          w_staged_next = (r_staged == '0) ? w_max : r_staged - 1'b1;
        end else if (w_ev[BTN_SET]) begin
          w_state_next = COMMIT;
        end
      end
      COMMIT: begin
        w_values_next[r_sel*VAL_W +: VAL_W] = r_staged;
        w_state_next                        = BROWSE;
      end
      default: w_state_next = BROWSE;
    endcase
  end

  always_ff @(posedge clk_65mhz) begin
    if (rst) begin
      r_state    <= BROWSE;
      r_sel      <= '0;
      r_staged   <= PARAM_RST[VAL_W-1:0];
      r_values   <= PARAM_RST;
      r_locked   <= 1'b0;
      r_owner    <= BTN_UP;
      r_both     <= 1'b0;
      r_suppress <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_sel    <= w_sel_next;
      r_staged <= w_staged_next;
      r_values <= w_values_next;
      r_both   <= up & down;
      if (!r_locked) begin
        if (|w_raw) begin
          r_locked <= 1'b1;
          r_owner  <= w_winner;
        end
      end else if (w_unlock) begin
        r_locked <= 1'b0;
      end
      if (w_cancel)      r_suppress <= 1'b1;
      else if (w_unlock) r_suppress <= 1'b0;
    end
  end

  assign values       = r_values;
  assign staged_val   = (r_state == BROWSE) ? w_cur : r_staged;
  assign selector_val = r_sel;
  assign editing      = (r_state == EDIT);
  assign commit_pulse = (r_state == COMMIT);
  assign menu_state   = r_state;

endmodule

`default_nettype wire
